voice_udp_packer: RTL

- Single-clock, parametrised audio-to-UDP payload packer.
- Takes N-channel PCM sample frames, serialises them big-endian into a byte FIFO, and presents fixed-length UDP payloads to the MAC/UDP sender through a request/read handshake.
- Optionally prepends a 16-bit packet sequence number.
- Replaces the fixed single-channel 8-bit voice cache/FIFO path and adds overflow accounting.

---
 rtl/voice_pkt_pkg.sv | 26 ++
 rtl/sync_byte_fifo.sv | 54 +++++
 rtl/voice_udp_packer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/voice_pkt_pkg.sv
// Shared types and size helpers for the voice UDP payload packer.
// Reader states, sequence width and byte-count arithmetic.
package voice_pkt_pkg;

    localparam int SEQ_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA
    } rd_state_e;

    function automatic int calc_sb(input int sample_w);
        return sample_w / 8;
    endfunction

    function automatic int calc_fb(input int ch_num, input int sample_w);
        return ch_num * (sample_w / 8);
    endfunction

    function automatic int calc_pkt_len(input int payload_bytes, input int seq_en);
        return payload_bytes + ((seq_en != 0) ? 2 : 0);
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with registered read data and a fill level.
// Pushes to a full FIFO and pops from an empty one are ignored.
module sync_byte_fifo #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic [AW:0] level
);

    localparam int DEPTH = 2 ** AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = wr_en && (level != (AW+1)'(DEPTH));
    assign do_rd = rd_en && (level != '0);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
            level   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/voice_udp_packer.sv
// Packs N-channel PCM frames big-endian into a byte FIFO and serves
// fixed-length UDP payloads, optionally led by a 16-bit sequence number.
module voice_udp_packer
    import voice_pkt_pkg::*;
#(
    parameter int CH_NUM        = 2,
    parameter int SAMPLE_W      = 16,
    parameter int PAYLOAD_BYTES = 1024,
    parameter int FIFO_AW       = 11,
    parameter int SEQ_EN        = 1
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         smp_valid,
    input  logic [CH_NUM*SAMPLE_W-1:0]   smp_data,
    output logic                         pkt_ready,
    input  logic                         pkt_start,
    input  logic                         pkt_rd_en,
    output logic [7:0]                   pkt_data,
    output logic                         pkt_valid,
    output logic                         pkt_last,
    output logic [FIFO_AW:0]             fifo_level,
    output logic [15:0]                  ovf_cnt
);

    localparam int SB    = calc_sb(SAMPLE_W);
    localparam int FB    = calc_fb(CH_NUM, SAMPLE_W);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BCW   = (FB > 1) ? $clog2(FB) : 1;
    localparam int DCW   = $clog2(PAYLOAD_BYTES + 1);

    logic [FB*8-1:0]    ordered;
    logic [FB*8-1:0]    shreg;
    logic               ser_busy;
    logic [BCW-1:0]     ser_cnt;
    logic [FIFO_AW+1:0] free_bytes;
    logic               accept;

    rd_state_e          state;
    rd_state_e          state_nx;
    logic [DCW-1:0]     dcnt;
    logic [SEQ_W-1:0]   seq;
    logic               data_last;
    logic               pop;
    logic               from_fifo;
    logic [7:0]         hdr_byte;
    logic [7:0]         fifo_rd_data;

    // Byte k of the frame sits at ordered[8k +: 8]: channel 0 first, MSB first.
    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        for (genvar b = 0; b < SB; b++) begin : g_byte
            assign ordered[(c*SB+b)*8 +: 8] =
                smp_data[c*SAMPLE_W + (SB-1-b)*8 +: 8];
        end
    end

    assign free_bytes = (FIFO_AW+2)'(DEPTH) - {1'b0, fifo_level};
    assign accept     = smp_valid && !ser_busy &&
                        (free_bytes >= (FIFO_AW+2)'(FB));

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            shreg    <= '0;
            ser_busy <= 1'b0;
            ser_cnt  <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (accept) begin
                shreg    <= ordered;
                ser_busy <= 1'b1;
                ser_cnt  <= '0;
            end else if (ser_busy) begin
                shreg   <= shreg >> 8;
                ser_cnt <= ser_cnt + 1'b1;
                if (ser_cnt == BCW'(FB - 1)) begin
                    ser_busy <= 1'b0;
                end
            end
            if (smp_valid && !accept && (ovf_cnt != 16'hFFFF)) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end

    assign data_last = (state == DATA) && (dcnt == DCW'(PAYLOAD_BYTES - 1));
    assign pop       = pkt_rd_en && (state == DATA);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pkt_start && pkt_ready)
                         state_nx = (SEQ_EN != 0) ? HDR_HI : DATA;
            HDR_HI:  if (pkt_rd_en) state_nx = HDR_LO;
            HDR_LO:  if (pkt_rd_en) state_nx = DATA;
            DATA:    if (pkt_rd_en && data_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // pkt_ready waits one IDLE cycle so the level already reflects the last pop.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= IDLE;
            dcnt      <= '0;
            seq       <= '0;
            pkt_ready <= 1'b0;
            pkt_valid <= 1'b0;
            pkt_last  <= 1'b0;
            from_fifo <= 1'b0;
            hdr_byte  <= '0;
        end else begin
            state     <= state_nx;
            pkt_ready <= (state == IDLE) && (state_nx == IDLE) &&
                         (fifo_level >= (FIFO_AW+1)'(PAYLOAD_BYTES));
            pkt_valid <= pkt_rd_en && (state != IDLE);
            pkt_last  <= pkt_rd_en && data_last;
            from_fifo <= (state == DATA);
            if (pkt_rd_en) begin
                hdr_byte <= (state == HDR_HI) ? seq[SEQ_W-1:8] : seq[7:0];
            end
            if (state == IDLE) begin
                dcnt <= '0;
            end else if (pop) begin
                dcnt <= dcnt + 1'b1;
            end
            if (pkt_rd_en && data_last) begin
                seq <= seq + 1'b1;
            end
        end
    end

    assign pkt_data = from_fifo ? fifo_rd_data : hdr_byte;

    sync_byte_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (rst),
        .wr_en   (ser_busy),
        .wr_data (shreg[7:0]),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .level   (fifo_level)
    );

endmodule
